imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Streams bytes from a valid/ready byte source, packs them little-endian
//   into 32-bit words and writes them to the instruction memory at
//   consecutive word addresses starting at 0. While loading, the core is
//   held in reset; once the requested number of words has been written the
//   core reset is released (cpu_rst_n follows the sticky done flag).
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, num_words       : one-cycle load request and word count (1..1024)
//   byte_valid, byte_data  : byte source
//   byte_ready             : byte accepted this cycle when byte_valid is high
//   WE, As, WD             : instruction memory write port (word address)
//   busy                   : load in progress (receiving or writing)
//   done                   : sticky, last load completed
//   error                  : sticky, last start rejected or load timed out
//   cpu_rst_n              : core reset, released only while done is set
//
// Parameter
//   TIMEOUT_CYCLES         : consecutive receive cycles without a byte
//                            before the load is abandoned
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        WE,
  output logic [9:0]  As,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

  // Idle counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [9:0]    addr_q,  addr_d;
  logic [9:0]    last_q,  last_d;   // address of the final word of this load
  logic [1:0]    idx_q,   idx_d;    // byte lane of the next transfer
  logic [31:0]   word_q,  word_d;
  logic [CW-1:0] idle_q,  idle_d;
  logic          done_q,  done_d;
  logic          error_q, error_d;

  logic          start_ok;
  logic          xfer;
  logic [CW-1:0] idle_inc;

  assign start_ok = (num_words != 11'd0) && (num_words <= 11'd1024);
  assign xfer     = (state_q == S_RECV) && byte_valid;
  assign idle_inc = idle_q + {{(CW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    idx_d   = idx_q;
    word_d  = word_q;
    idle_d  = idle_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            // 10-bit wrap maps a count of 1024 onto last address 1023.
            last_d  = num_words[9:0] - 10'd1;
            addr_d  = '0;
            idx_d   = '0;
            idle_d  = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            state_d = S_RECV;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      S_RECV: begin
        if (xfer) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d  = idx_q + 2'd1;
          idle_d = '0;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end else if (idle_inc == CW'(TIMEOUT_CYCLES)) begin
          // Abandon the load; the partial word is never written.
          error_d = 1'b1;
          idx_d   = '0;
          idle_d  = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_inc;
        end
      end

      S_WRITE: begin
        if (addr_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 10'd1;
          idx_d   = '0;
          idle_d  = '0;
          state_d = S_RECV;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign byte_ready = (state_q == S_RECV);
  assign WE         = (state_q == S_WRITE);
  assign As         = addr_q;
  assign WD         = word_q;
  assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_rst_n  = done_q;

endmodule
